// File: rtl/temp_sample_scheduler.sv
// Periodic round-robin scheduler presenting enabled sensor channels to the
// averager over valid/ready; counts rounds dropped because the last one was still running.
//
// Ports:
//   clk, rst       - clock, synchronous active-low reset
//   ch_en          - per-channel enable mask, latched at round start
//   temp_in        - packed samples, ch k at [k*DATA_W +: DATA_W]
//   out_valid      - sample valid towards the averager
//   out_ready      - averager accepts the sample
//   out_data       - presented sample
//   out_ch         - channel index of out_data
//   busy           - round in progress
//   round_done     - pulse after the last handshake of a round
//   overrun        - pulse when a tick arrives while busy
//   overrun_cnt    - saturating overrun count
module temp_sample_scheduler #(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 9,
   parameter int PERIOD   = 50_000_000,
   parameter int PERIOD_W = 26,
   localparam int CH_W    = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic [NUM_CH*DATA_W-1:0] temp_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic                     busy,
   output logic                     round_done,
   output logic                     overrun,
   output logic [7:0]               overrun_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      PRESENT
   } state_t;

   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [CH_W-1:0]     ptr_q, ptr_d;
   logic [NUM_CH-1:0]   en_q, en_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                done_q, done_d;
   logic                ovr_q, ovr_d;
   logic [7:0]          ovr_cnt_q, ovr_cnt_d;
   logic                tick;
   logic                last;

   always_comb begin
      tick      = (cnt_q == PERIOD_W'(PERIOD - 1));
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      last      = (ptr_q == CH_W'(NUM_CH - 1));
      state_d   = state_q;
      ptr_d     = ptr_q;
      en_d      = en_q;
      valid_d   = valid_q;
      data_d    = data_q;
      ch_d      = ch_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick && (|ch_en)) begin
               en_d    = ch_en;
               ptr_d   = '0;
               state_d = SELECT;
            end
         end
         SELECT: begin
            if (en_q[ptr_q]) begin
               data_d  = temp_in[ptr_q*DATA_W +: DATA_W];
               ch_d    = ptr_q;
               valid_d = 1'b1;
               state_d = PRESENT;
            end else if (last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = SELECT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Registered overrun: look one cycle ahead so the pulse lands
      // on the very cycle the tick meets a busy FSM.
      ovr_d     = (cnt_d == PERIOD_W'(PERIOD - 1)) && (state_d != IDLE);
      ovr_cnt_d = ovr_cnt_q;
      if (ovr_d && (ovr_cnt_q != 8'hFF))
         ovr_cnt_d = ovr_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ptr_q     <= '0;
         en_q      <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         ch_q      <= '0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
         ovr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         en_q      <= en_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         ch_q      <= ch_d;
         done_q    <= done_d;
         ovr_q     <= ovr_d;
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_data    = data_q;
   assign out_ch      = ch_q;
   assign busy        = (state_q != IDLE);
   assign round_done  = done_q;
   assign overrun     = ovr_q;
   assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_temp_sample_scheduler.sv
// Directed bench for temp_sample_scheduler, PERIOD=16, NUM_CH=4.
// Samples at the falling edge; inputs driven at the falling edge.
module tb_temp_sample_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ch_en;
   logic [35:0] temp_in;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  out_data;
   logic [1:0]  out_ch;
   logic        busy;
   logic        round_done;
   logic        overrun;
   logic [7:0]  overrun_cnt;

   int total = 0;
   int bad   = 0;

   temp_sample_scheduler #(
      .NUM_CH(4),
      .DATA_W(9),
      .PERIOD(16),
      .PERIOD_W(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ch_en(ch_en),
      .temp_in(temp_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_ch(out_ch),
      .busy(busy),
      .round_done(round_done),
      .overrun(overrun),
      .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench on the first busy cycle (tick + 1).
   task automatic wait_busy();
      int n = 0;
      do begin
         step();
         n++;
      end while (!busy && n < 40);
      chk("wait_busy", {31'd0, busy}, 32'd1);
   endtask

   // Called on the first SELECT cycle with out_ready=1; ends on round_done.
   task automatic run_round(input logic [3:0] en);
      for (int k = 0; k < 4; k++) begin
         chk("sel_valid", {31'd0, out_valid}, 32'd0);
         step();
         if (en[k]) begin
            chk("pre_valid", {31'd0, out_valid}, 32'd1);
            chk("pre_ch", {30'd0, out_ch}, k);
            chk("pre_data", {23'd0, out_data}, (k + 1) * 10);
            step();
         end
      end
      chk("rd_done", {31'd0, round_done}, 32'd1);
      chk("rd_busy", {31'd0, busy}, 32'd0);
      chk("rd_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst       = 1'b0;
      ch_en     = 4'hF;
      out_ready = 1'b1;
      temp_in   = {9'd40, 9'd30, 9'd20, 9'd10};
      repeat (3) step();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, round_done}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
      chk("rst_cnt", {24'd0, overrun_cnt}, 32'd0);
      rst = 1'b1;

      // full round, then idle until the next tick 16 cycles later
      wait_busy();
      run_round(4'hF);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("gap_busy", {31'd0, busy}, 32'd0);
         chk("gap_ovr", {31'd0, overrun}, 32'd0);
      end
      step();
      chk("next_busy", {31'd0, busy}, 32'd1);
      run_round(4'hF);

      // sparse mask
      ch_en = 4'b1010;
      wait_busy();
      run_round(4'b1010);
      step();
      chk("sparse_once", {31'd0, round_done}, 32'd0);

      // backpressure across two ticks
      ch_en = 4'hF;
      wait_busy();
      chk("bp_sel", {31'd0, out_valid}, 32'd0);
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 30; i++) begin
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_data", {23'd0, out_data}, 32'd10);
         chk("bp_ch", {30'd0, out_ch}, 32'd0);
         chk("bp_ovr", {31'd0, overrun}, {31'd0, i == 14});
         if (i == 13) chk("bp_cnt0", {24'd0, overrun_cnt}, 32'd0);
         if (i == 14) chk("bp_cnt1", {24'd0, overrun_cnt}, 32'd1);
         step();
      end
      out_ready = 1'b1;
      chk("bp_ovr_hs", {31'd0, overrun}, 32'd1);
      chk("bp_cnt2", {24'd0, overrun_cnt}, 32'd2);
      chk("bp_hold", {31'd0, out_valid}, 32'd1);
      step();
      for (int k = 1; k < 4; k++) begin
         chk("bp_sel_v", {31'd0, out_valid}, 32'd0);
         step();
         chk("bp_pre_ch", {30'd0, out_ch}, k);
         chk("bp_pre_d", {23'd0, out_data}, (k + 1) * 10);
         step();
      end
      chk("bp_done", {31'd0, round_done}, 32'd1);

      // nothing enabled over three ticks
      ch_en = 4'h0;
      for (int i = 0; i < 50; i++) begin
         step();
         chk("none_quiet",
             {28'd0, out_valid, round_done, overrun, busy}, 32'd0);
      end

      // mask change mid-round applies next round
      ch_en = 4'hF;
      wait_busy();
      ch_en = 4'h1;
      run_round(4'hF);
      wait_busy();
      run_round(4'h1);

      // reset while PRESENT
      ch_en     = 4'hF;
      out_ready = 1'b0;
      wait_busy();
      step();
      chk("mr_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b0;
      step();
      chk("mr_valid0", {31'd0, out_valid}, 32'd0);
      chk("mr_busy0", {31'd0, busy}, 32'd0);
      chk("mr_cnt0", {24'd0, overrun_cnt}, 32'd0);
      chk("mr_flags", {30'd0, round_done, overrun}, 32'd0);
      step();
      rst       = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         chk("mr_quiet", {29'd0, busy, out_valid, round_done}, 32'd0);
      end
      step();
      chk("mr_first", {31'd0, busy}, 32'd1);

      // stall forever: overrun count saturates at 255
      for (int i = 0; i < 16 * 256 + 8; i++) step();
      chk("sat_cnt", {24'd0, overrun_cnt}, 32'd255);
      chk("sat_valid", {31'd0, out_valid}, 32'd1);
      chk("sat_data", {23'd0, out_data}, 32'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
